// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. Owns the fetch PC, runs a single-outstanding
//   request/grant/response handshake to instruction memory, and presents each
//   fetched instruction (pc_curr_IF / instr_IF / if_valid) to the IF/ID
//   boundary until the ID stage consumes it. A redirect from EX replaces the
//   fetch PC and squashes whatever fetch is in flight.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,

    // ID-stage back-pressure and EX-stage redirect
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    // Instruction memory request/grant/response
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    // IF/ID presentation
    output logic [31:0] pc_curr_IF,
    output logic [31:0] instr_IF,
    output logic        if_valid
);

    // REQ  : request on the bus, waiting for a grant
    // WAIT : request granted, waiting for the response
    // HOLD : instruction presented, waiting for ID to consume it
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state,      state_nxt;
    logic [31:0] fetch_pc,   fetch_pc_nxt;
    logic        kill,       kill_nxt;
    logic [31:0] pc_curr_q,  pc_curr_nxt;
    logic [31:0] instr_q,    instr_nxt;
    logic        valid_q,    valid_nxt;

    // Redirect targets are always word aligned; the low two bits are dropped.
    logic [31:0] redirect_target;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    // The fetch address is the fetch PC at all times; a request is raised
    // only while waiting for a grant.
    assign imem_req   = (state == S_REQ);
    assign imem_addr  = fetch_pc;
    assign pc_curr_IF = pc_curr_q;
    assign instr_IF   = instr_q;
    assign if_valid   = valid_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC, kill flag and IF/ID presentation registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            pc_curr_q <= 32'h0000_0000;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            kill      <= kill_nxt;
            pc_curr_q <= pc_curr_nxt;
            instr_q   <= instr_nxt;
            valid_q   <= valid_nxt;
        end
    end

    // Next-state and next-register logic. A redirect takes priority over the
    // normal flow and over stall; otherwise each state follows the handshake.
    always_comb begin
        // NOTE: every signal written here gets a hold-value default first so
        // no path through the case statements can infer a latch.
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        kill_nxt     = kill;
        pc_curr_nxt  = pc_curr_q;
        instr_nxt    = instr_q;
        valid_nxt    = valid_q;

        if (redirect_valid) begin
            // Common redirect effects: new PC, drop any presented instruction.
            fetch_pc_nxt = redirect_target;
            valid_nxt    = 1'b0;
            instr_nxt    = NOP_INSTR;

            unique case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        // The old-PC request was accepted this cycle; its
                        // response must be thrown away when it arrives.
                        state_nxt = S_WAIT;
                        kill_nxt  = 1'b1;
                    end
                    // Without a grant the new address simply goes out next
                    // cycle; nothing is in flight.
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        // The stale response lands this very cycle: drop it
                        // and go straight back to requesting the new PC.
                        state_nxt = S_REQ;
                        kill_nxt  = 1'b0;
                    end else begin
                        kill_nxt  = 1'b1;
                    end
                end

                S_HOLD: begin
                    // The held instruction is on the wrong path.
                    state_nxt = S_REQ;
                end

                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    // Address stays stable until the memory grants it.
                    if (imem_gnt) begin
                        state_nxt = S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill) begin
                            // Response belongs to a squashed fetch; the fetch
                            // PC already holds the redirect target.
                            kill_nxt  = 1'b0;
                            state_nxt = S_REQ;
                        end else begin
                            pc_curr_nxt  = fetch_pc;
                            instr_nxt    = imem_rdata;
                            valid_nxt    = 1'b1;
                            fetch_pc_nxt = fetch_pc + 32'd4;
                            state_nxt    = S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // ID takes the instruction on any edge where stall is low.
                    if (!stall) begin
                        valid_nxt = 1'b0;
                        instr_nxt = NOP_INSTR;
                        state_nxt = S_REQ;
                    end
                end

                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Randomized bench for if_fetch_unit. A driver issues memory handshake,
//   stall and redirect stimulus on the falling edge and advances a
//   transaction-level model of the fetch stream; every instruction the model
//   says will be presented is pushed into a queue. An independent monitor
//   samples the DUT after each rising edge and pops/compares whenever a new
//   instruction appears on the IF/ID outputs.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    // Reset PC near the top of the address space so the modulo wrap of the
    // fetch PC is exercised within the first few instructions.
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_curr_IF;
    logic [31:0] instr_IF;
    logic        if_valid;

    if_fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_curr_IF     (pc_curr_IF),
        .instr_IF       (instr_IF),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    // Transaction-level model of the fetch stream.
    logic [31:0] model_pc;     // address the unit will fetch next
    logic [31:0] granted_pc;   // address of the outstanding request
    bit          outstanding;  // a granted request awaits its response
    bit          live;         // that response will be presented
    bit          exp_valid;    // an instruction is being presented

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_pc    = RST_PC;
        granted_pc  = RST_PC;
        outstanding = 1'b0;
        live        = 1'b0;
        exp_valid   = 1'b0;
        exp_q.delete();
    endtask

    // One cycle of stimulus: check the request side, drive inputs for the
    // coming rising edge, then advance the model across that edge.
    task automatic step(input bit redir, input logic [31:0] tgt,
                        input bit g, input bit rv, input bit st);
        bit          req_e;
        logic [31:0] d;
        @(negedge clk);
        req_e = !outstanding && !exp_valid;
        check("imem_req", imem_req, req_e);
        check("imem_addr", imem_addr, model_pc);

        d              = $urandom;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = d;
        stall          = st;

        if (exp_valid && (redir || !st))
            exp_valid = 1'b0;

        if (redir) begin
            model_pc = tgt & ~32'h3;
            if (req_e && g) begin
                outstanding = 1'b1;
                live        = 1'b0;
            end else if (outstanding && rv) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                live = 1'b0;
            end
        end else begin
            if (req_e && g) begin
                outstanding = 1'b1;
                live        = 1'b1;
                granted_pc  = model_pc;
            end else if (outstanding && rv) begin
                outstanding = 1'b0;
                if (live) begin
                    exp_q.push_back('{pc: granted_pc, instr: d});
                    model_pc  = granted_pc + 32'd4;
                    exp_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic random_step();
        bit          redir;
        logic [31:0] tgt;
        redir = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 3) == 0)
            tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else
            tgt = $urandom;
        step(redir, tgt, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50);
    endtask

    // Monitor: compares the IF/ID outputs after every rising edge.
    initial begin : monitor
        bit     prev_valid;
        fetch_t last;
        fetch_t e;
        prev_valid = 1'b0;
        last       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                check("if_valid", if_valid, exp_valid);
                if (if_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr: got pc %h instr %h, none expected at %0t",
                                 pc_curr_IF, instr_IF, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pc_curr_IF", pc_curr_IF, e.pc);
                        check("instr_IF", instr_IF, e.instr);
                        last = e;
                    end
                end else if (if_valid) begin
                    check("held_pc", pc_curr_IF, last.pc);
                    check("held_instr", instr_IF, last.instr);
                end else begin
                    check("idle_instr", instr_IF, NOP);
                end
            end
            prev_valid = if_valid;
        end
    end

    // Driver: directed opening, random traffic, async reset mid-WAIT, more
    // random traffic, then summary.
    initial begin : driver
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        model_reset();

        #12;
        check("rst_imem_req", imem_req, 1'b1);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_instr", instr_IF, NOP);
        check("rst_pc_curr", pc_curr_IF, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back fetches across the address wrap, each held by stall.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);   // grant
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);   // response
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);   // stalled in HOLD
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);   // consumed
        end
        // Ungranted request held for several cycles.
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        // Redirect to 0x103 while waiting; the late response is dropped.
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h103, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0,   1'b1, 1'b0, 1'b0);   // request 0x100
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1);   // present 0x100
        // Redirect together with stall in HOLD.
        step(1'b1, 32'h40,  1'b0, 1'b0, 1'b1);
        // Redirect in the same cycle as a grant.
        step(1'b1, 32'h80,  1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++)
            random_step();

        // Get a request granted, then reset asynchronously mid-WAIT.
        for (int i = 0; i < 20 && !outstanding; i++)
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("reached_wait", 32'(outstanding), 32'd1);
        @(posedge clk);
        #2;
        reset    = 1'b1;
        imem_gnt = 1'b0;
        #1;
        check("async_rst_if_valid", if_valid, 1'b0);
        check("async_rst_instr", instr_IF, NOP);
        check("async_rst_pc_curr", pc_curr_IF, 32'h0);
        check("async_rst_imem_req", imem_req, 1'b1);
        check("async_rst_imem_addr", imem_addr, RST_PC);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // Stale responses arrive with no request granted: ignored.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++)
            random_step();

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
